// File: rtl/dlsc_pcie_tlpbuffer.sv
// dlsc_pcie_tlpbuffer
// Single-clock TLP buffer placed between TLP formatter/parser logic and the
// core's TX/RX streaming interface. Stores data words plus an end-of-packet
// flag and releases them as ready/valid packets.
//   STORE_FWD=0 : cut-through; the first word of a TLP is held until HOLD
//                 words are buffered or the whole TLP is present.
//   STORE_FWD=1 : store-and-forward; a TLP is released only once complete.
//
// Optional build macro: DLSC_PCIE_TLPBUFFER_DISCARD_EN
//   Adds input wr_discard, which drops the partially written TLP (only
//   effective with STORE_FWD=1).
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   wr_ready/valid     write handshake; wr_last marks final TLP word
//   wr_data[DATA]      write word
//   wr_discard         (macro only) drop uncommitted words
//   rd_ready/valid     read handshake; rd_last marks final TLP word
//   rd_data[DATA]      read word (combinational from storage)
//   count[ADDR+1]      words occupied, including uncommitted words
//   pkt_count[ADDR+1]  complete TLPs held
module dlsc_pcie_tlpbuffer #(
    parameter int DATA      = 32,
    parameter int ADDR      = 4,
    parameter int HOLD      = 3,
    parameter int STORE_FWD = 0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            wr_ready,
    input  logic            wr_valid,
    input  logic            wr_last,
    input  logic [DATA-1:0] wr_data,
`ifdef DLSC_PCIE_TLPBUFFER_DISCARD_EN
    input  logic            wr_discard,
`endif
    input  logic            rd_ready,
    output logic            rd_valid,
    output logic            rd_last,
    output logic [DATA-1:0] rd_data,
    output logic [ADDR:0]   count,
    output logic [ADDR:0]   pkt_count
);

    localparam int unsigned DEPTH   = 2**ADDR;
    localparam logic [ADDR:0] DEPTH_C = (ADDR+1)'(DEPTH);
    localparam logic [ADDR:0] HOLD_C  = (ADDR+1)'(HOLD);

    logic [DATA:0]   mem_q [DEPTH];

    logic [ADDR-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR:0]   count_q, count_d;
    logic [ADDR:0]   pkt_count_q, pkt_count_d;
    logic            rd_first_q, rd_first_d;

    logic            push;
    logic            pop;
    logic            discard;

`ifdef DLSC_PCIE_TLPBUFFER_DISCARD_EN
    logic [ADDR-1:0] commit_ptr_q, commit_ptr_d;
    // Separate uncommitted-word counter: wr_ptr - commit_ptr cannot tell
    // "none" from "a full buffer's worth" once the pointers wrap.
    logic [ADDR:0]   uncommit_q, uncommit_d;

    assign discard = wr_discard && (STORE_FWD != 0);
`else
    assign discard = 1'b0;
`endif

    assign wr_ready  = (count_q != DEPTH_C);
    assign push      = wr_valid && wr_ready && !discard;
    assign pop       = rd_valid && rd_ready;
    assign {rd_last, rd_data} = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign pkt_count = pkt_count_q;

    always_comb begin
        rd_valid = 1'b0;
        if (STORE_FWD != 0) begin
            rd_valid = (pkt_count_q != '0);
        end else begin
            // At a TLP boundary the head word waits for HOLD words or a
            // complete TLP; mid-TLP every buffered word goes straight out.
            rd_valid = (count_q != '0) &&
                       (!rd_first_q || (pkt_count_q != '0) || (count_q >= HOLD_C));
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pkt_count_d = pkt_count_q;
        rd_first_d  = rd_first_q;
`ifdef DLSC_PCIE_TLPBUFFER_DISCARD_EN
        commit_ptr_d = commit_ptr_q;
        uncommit_d   = uncommit_q;
`endif

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            rd_first_d = rd_last;
        end

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if ((push && wr_last) && !(pop && rd_last)) begin
            pkt_count_d = pkt_count_q + 1'b1;
        end else if ((pop && rd_last) && !(push && wr_last)) begin
            pkt_count_d = pkt_count_q - 1'b1;
        end

`ifdef DLSC_PCIE_TLPBUFFER_DISCARD_EN
        if (discard) begin
            // push is already suppressed; any pop was applied above.
            wr_ptr_d   = commit_ptr_q;
            count_d    = count_d - uncommit_q;
            uncommit_d = '0;
        end else if (push) begin
            if (wr_last) begin
                commit_ptr_d = wr_ptr_q + 1'b1;
                uncommit_d   = '0;
            end else begin
                uncommit_d = uncommit_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {wr_last, wr_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pkt_count_q <= '0;
            rd_first_q  <= 1'b1;
`ifdef DLSC_PCIE_TLPBUFFER_DISCARD_EN
            commit_ptr_q <= '0;
            uncommit_q   <= '0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pkt_count_q <= pkt_count_d;
            rd_first_q  <= rd_first_d;
`ifdef DLSC_PCIE_TLPBUFFER_DISCARD_EN
            commit_ptr_q <= commit_ptr_d;
            uncommit_q   <= uncommit_d;
`endif
        end
    end

endmodule

// File: tb/tb_dlsc_pcie_tlpbuffer.sv
// Testbench for dlsc_pcie_tlpbuffer: one cut-through instance (ct_*) and one
// store-and-forward instance (sf_*), each with a scoreboard monitor.
module tb_dlsc_pcie_tlpbuffer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        ct_wr_ready, ct_rd_valid, ct_rd_last;
    logic        ct_wr_valid = 1'b0, ct_wr_last = 1'b0, ct_rd_ready = 1'b0;
    logic [31:0] ct_wr_data = '0, ct_rd_data;
    logic [4:0]  ct_count, ct_pkt_count;

    logic        sf_wr_ready, sf_rd_valid, sf_rd_last;
    logic        sf_wr_valid = 1'b0, sf_wr_last = 1'b0, sf_rd_ready = 1'b0;
    logic [31:0] sf_wr_data = '0, sf_rd_data;
    logic [4:0]  sf_count, sf_pkt_count;
`ifdef DLSC_PCIE_TLPBUFFER_DISCARD_EN
    logic        ct_wr_discard = 1'b0, sf_wr_discard = 1'b0;
`endif

    dlsc_pcie_tlpbuffer #(.DATA(32), .ADDR(4), .HOLD(3), .STORE_FWD(0)) u_ct (
        .clk(clk), .rst(rst),
        .wr_ready(ct_wr_ready), .wr_valid(ct_wr_valid), .wr_last(ct_wr_last), .wr_data(ct_wr_data),
`ifdef DLSC_PCIE_TLPBUFFER_DISCARD_EN
        .wr_discard(ct_wr_discard),
`endif
        .rd_ready(ct_rd_ready), .rd_valid(ct_rd_valid), .rd_last(ct_rd_last), .rd_data(ct_rd_data),
        .count(ct_count), .pkt_count(ct_pkt_count)
    );

    dlsc_pcie_tlpbuffer #(.DATA(32), .ADDR(4), .HOLD(3), .STORE_FWD(1)) u_sf (
        .clk(clk), .rst(rst),
        .wr_ready(sf_wr_ready), .wr_valid(sf_wr_valid), .wr_last(sf_wr_last), .wr_data(sf_wr_data),
`ifdef DLSC_PCIE_TLPBUFFER_DISCARD_EN
        .wr_discard(sf_wr_discard),
`endif
        .rd_ready(sf_rd_ready), .rd_valid(sf_rd_valid), .rd_last(sf_rd_last), .rd_data(sf_rd_data),
        .count(sf_count), .pkt_count(sf_pkt_count)
    );

    int checks = 0;
    int errors = 0;
    int ct_max = 0;
    bit rnd_rd = 1'b0;
    bit ct_hold = 1'b0, sf_hold = 1'b0;
    logic [32:0] ct_q[$], sf_q[$], sf_pend[$];
    logic [32:0] ct_e, sf_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=no-event", name);
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        to_neg();
        to_pos();
    endtask

    // Cut-through scoreboard: accepted words are expected in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (ct_wr_valid && ct_wr_ready) ct_q.push_back({ct_wr_last, ct_wr_data});
            if (ct_hold) chk("ct_valid_sticky", ct_rd_valid, 1);
            if (ct_rd_valid && ct_rd_ready) begin
                if (ct_q.size() == 0) note_fail("ct_unexpected_word");
                else begin
                    ct_e = ct_q.pop_front();
                    chk("ct_rd_word", {ct_rd_last, ct_rd_data}, ct_e);
                end
            end
            ct_hold = ct_rd_valid && !ct_rd_ready;
            if (int'(ct_count) > ct_max) ct_max = int'(ct_count);
        end
    end

    // Store-and-forward scoreboard: words become expected only once their
    // TLP's last word is accepted; a discard drops the pending words.
    always @(negedge clk) begin
        if (!rst) begin
`ifdef DLSC_PCIE_TLPBUFFER_DISCARD_EN
            if (sf_wr_discard) sf_pend.delete();
            else
`endif
            if (sf_wr_valid && sf_wr_ready) begin
                sf_pend.push_back({sf_wr_last, sf_wr_data});
                if (sf_wr_last) begin
                    while (sf_pend.size() > 0) sf_q.push_back(sf_pend.pop_front());
                end
            end
            if (sf_hold) chk("sf_valid_sticky", sf_rd_valid, 1);
            if (sf_rd_valid && sf_rd_ready) begin
                if (sf_q.size() == 0) note_fail("sf_unexpected_word");
                else begin
                    sf_e = sf_q.pop_front();
                    chk("sf_rd_word", {sf_rd_last, sf_rd_data}, sf_e);
                end
            end
            sf_hold = sf_rd_valid && !sf_rd_ready;
        end
    end

    always @(posedge clk) begin
        if (rnd_rd) begin
            #1;
            ct_rd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic ct_send(input int len, input logic [31:0] base, input bit with_last);
        int n;
        for (int i = 0; i < len; i++) begin
            ct_wr_valid = 1'b1;
            ct_wr_data  = base + 32'(i);
            ct_wr_last  = with_last && (i == len - 1);
            to_neg();
            n = 0;
            while (!ct_wr_ready && n < 100) begin
                to_pos();
                to_neg();
                n++;
            end
            if (!ct_wr_ready) note_fail("ct_wr_ready_timeout");
            to_pos();
        end
        ct_wr_valid = 1'b0;
        ct_wr_last  = 1'b0;
    endtask

    task automatic sf_send(input int len, input logic [31:0] base, input bit with_last);
        int n;
        for (int i = 0; i < len; i++) begin
            sf_wr_valid = 1'b1;
            sf_wr_data  = base + 32'(i);
            sf_wr_last  = with_last && (i == len - 1);
            to_neg();
            n = 0;
            while (!sf_wr_ready && n < 100) begin
                to_pos();
                to_neg();
                n++;
            end
            if (!sf_wr_ready) note_fail("sf_wr_ready_timeout");
            to_pos();
        end
        sf_wr_valid = 1'b0;
        sf_wr_last  = 1'b0;
    endtask

    task automatic ct_drain();
        int n = 0;
        to_neg();
        while (ct_count != 0 && n < 300) begin
            to_pos();
            to_neg();
            n++;
        end
        chk("ct_drain_count", ct_count, 0);
        to_pos();
    endtask

    task automatic sf_drain();
        int n = 0;
        to_neg();
        while (sf_count != 0 && n < 300) begin
            to_pos();
            to_neg();
            n++;
        end
        chk("sf_drain_count", sf_count, 0);
        to_pos();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int wbase;
        int len;

        // Reset state
        #2;
        chk("rst_ct_wr_ready", ct_wr_ready, 1);
        chk("rst_ct_rd_valid", ct_rd_valid, 0);
        chk("rst_ct_count", ct_count, 0);
        chk("rst_ct_pkt_count", ct_pkt_count, 0);
        chk("rst_sf_wr_ready", sf_wr_ready, 1);
        chk("rst_sf_rd_valid", sf_rd_valid, 0);
        chk("rst_sf_count", sf_count, 0);
        chk("rst_sf_pkt_count", sf_pkt_count, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        to_pos();

        // 1: single-word TLP, cut-through
        ct_wr_valid = 1'b1; ct_wr_last = 1'b1; ct_wr_data = 32'hA000_0001;
        to_neg();
        chk("t1_no_same_cycle_valid", ct_rd_valid, 0);
        to_pos();
        ct_wr_valid = 1'b0; ct_wr_last = 1'b0; ct_rd_ready = 1'b1;
        to_neg();
        chk("t1_rd_valid", ct_rd_valid, 1);
        chk("t1_rd_last", ct_rd_last, 1);
        chk("t1_pkt_count", ct_pkt_count, 1);
        to_pos();
        ct_rd_ready = 1'b0;
        to_neg();
        chk("t1_pkt_count_after", ct_pkt_count, 0);
        chk("t1_count_after", ct_count, 0);
        chk("t1_rd_valid_after", ct_rd_valid, 0);
        to_pos();

        // 2: HOLD threshold, cut-through
        ct_send(2, 32'hB000_0000, 1'b0);
        to_neg();
        chk("t2_two_words_held", ct_rd_valid, 0);
        chk("t2_count2", ct_count, 2);
        to_pos();
        ct_send(1, 32'hB000_0002, 1'b0);
        to_neg();
        chk("t2_hold_reached", ct_rd_valid, 1);
        chk("t2_count3", ct_count, 3);
        to_pos();
        repeat (3) cyc();
        to_neg();
        chk("t2_valid_during_stall", ct_rd_valid, 1);
        to_pos();
        ct_rd_ready = 1'b1;
        ct_send(3, 32'hB000_0003, 1'b1);
        ct_drain();
        ct_rd_ready = 1'b0;
        chk("t2_pkt_count", ct_pkt_count, 0);
        chk("t2_queue_empty", ct_q.size(), 0);

        // 3: store-and-forward release on completion
        sf_send(5, 32'hC000_0000, 1'b0);
        to_neg();
        chk("t3_partial_rd_valid", sf_rd_valid, 0);
        chk("t3_count5", sf_count, 5);
        chk("t3_pkt0", sf_pkt_count, 0);
        to_pos();
        sf_send(1, 32'hC000_0005, 1'b1);
        to_neg();
        chk("t3_complete_rd_valid", sf_rd_valid, 1);
        chk("t3_pkt1", sf_pkt_count, 1);
        chk("t3_count6", sf_count, 6);
        to_pos();
        sf_rd_ready = 1'b1;
        sf_drain();
        sf_rd_ready = 1'b0;
        chk("t3_pkt_after", sf_pkt_count, 0);
        chk("t3_queue_empty", sf_q.size(), 0);

        // 4: full buffer, push attempt with pop, pointer wrap
        sf_send(8, 32'hD000_0000, 1'b1);
        sf_send(8, 32'hD000_0008, 1'b1);
        to_neg();
        chk("t4_full_wr_ready", sf_wr_ready, 0);
        chk("t4_full_count", sf_count, 16);
        chk("t4_full_pkt", sf_pkt_count, 2);
        to_pos();
        sf_wr_valid = 1'b1; sf_wr_data = 32'hDEAD_BEEF; sf_wr_last = 1'b0; sf_rd_ready = 1'b1;
        to_neg();
        chk("t4_full_pop_wr_ready", sf_wr_ready, 0);
        to_pos();
        sf_wr_valid = 1'b0; sf_rd_ready = 1'b0;
        to_neg();
        chk("t4_after_pop_count", sf_count, 15);
        chk("t4_after_pop_wr_ready", sf_wr_ready, 1);
        to_pos();
        sf_rd_ready = 1'b1;
        for (int k = 0; k < 6; k++) sf_send(8, 32'hD100_0000 + 32'(k * 8), 1'b1);
        sf_drain();
        sf_rd_ready = 1'b0;
        chk("t4_pkt_after", sf_pkt_count, 0);
        chk("t4_queue_empty", sf_q.size(), 0);

        // 5: 200 TLPs, random reader, cut-through
        rnd_rd = 1'b1;
        wbase = 0;
        for (int p = 0; p < 200; p++) begin
            len = int'($urandom_range(1, 16));
            ct_send(len, 32'hE000_0000 + 32'(wbase), 1'b1);
            wbase += len;
        end
        rnd_rd = 1'b0;
        to_pos();
        ct_rd_ready = 1'b1;
        ct_drain();
        ct_rd_ready = 1'b0;
        chk("t5_count_over_depth", ct_max > 16, 0);
        chk("t5_pkt_after", ct_pkt_count, 0);
        chk("t5_queue_empty", ct_q.size(), 0);

`ifdef DLSC_PCIE_TLPBUFFER_DISCARD_EN
        // 6: discard partial TLP, store-and-forward
        sf_send(4, 32'hF000_0000, 1'b0);
        to_neg();
        chk("t6_count4", sf_count, 4);
        to_pos();
        sf_wr_discard = 1'b1; sf_wr_valid = 1'b1; sf_wr_data = 32'hBAD0_0000;
        cyc();
        sf_wr_discard = 1'b0; sf_wr_valid = 1'b0;
        to_neg();
        chk("t6_count_after_discard", sf_count, 0);
        chk("t6_pkt_after_discard", sf_pkt_count, 0);
        chk("t6_rd_valid_after_discard", sf_rd_valid, 0);
        to_pos();
        sf_send(3, 32'hF000_0010, 1'b1);
        sf_rd_ready = 1'b1;
        sf_drain();
        sf_rd_ready = 1'b0;
        chk("t6_queue_empty", sf_q.size(), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
